// File: rtl/rect_plot_engine_pkg.sv
// Shared constants and state encoding for the rectangle plot engine.
// Mode bits, default screen geometry and the engine FSM states.
package rect_plot_engine_pkg;

    localparam logic MODE_RECT  = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAW   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; the head word is readable
// combinationally one cycle after it is written.
module rect_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!resetn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rect_plot_engine.sv
// Queued rectangle / full-screen-clear fill engine: one clipped pixel per
// clock to the VGA adapter, one done pulse per command.
module rect_plot_engine
    import rect_plot_engine_pkg::*;
#(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int COLOUR_W   = COLOUR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          abort,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_mode,
    input  logic [X_W-1:0]                cmd_x,
    input  logic [Y_W-1:0]                cmd_y,
    input  logic [X_W-1:0]                cmd_w,
    input  logic [Y_W-1:0]                cmd_h,
    input  logic [COLOUR_W-1:0]           cmd_colour,
    output logic [X_W-1:0]                x,
    output logic [Y_W-1:0]                y,
    output logic [COLOUR_W-1:0]           colour,
    output logic                          plot,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CMD_W = 1 + 2*X_W + 2*Y_W + COLOUR_W;
    localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

    state_t                state, nstate;
    logic [CMD_W-1:0]      head;
    logic                  empty, full, push, pop, draw;

    logic                  h_mode;
    logic [X_W-1:0]        h_x, h_w;
    logic [Y_W-1:0]        h_y, h_h;
    logic [COLOUR_W-1:0]   h_colour;

    logic [X_W:0]          room_x, clip_w, eff_w, cx;
    logic [Y_W:0]          room_y, clip_h, eff_h, cy;
    logic [X_W-1:0]        base_x;
    logic [Y_W-1:0]        base_y;
    logic [COLOUR_W-1:0]   fill;
    logic                  last_col, last_row;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !abort;
    assign busy      = (state != S_IDLE) || !empty;

    rect_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .flush  (abort),
        .push   (push),
        .pop    (pop),
        .wdata  ({cmd_mode, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour}),
        .rdata  (head),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );

    assign {h_mode, h_x, h_y, h_w, h_h, h_colour} = head;

    // Extra top bit keeps x + w from wrapping; room_* is only used on-screen.
    always_comb begin
        room_x = SW - {1'b0, h_x};
        room_y = SH - {1'b0, h_y};
        clip_w = '0;
        clip_h = '0;
        if ({1'b0, h_x} < SW)
            clip_w = ({1'b0, h_w} < room_x) ? {1'b0, h_w} : room_x;
        if ({1'b0, h_y} < SH)
            clip_h = ({1'b0, h_h} < room_y) ? {1'b0, h_h} : room_y;
        if (h_mode == MODE_CLEAR) begin
            clip_w = SW;
            clip_h = SH;
        end
    end

    assign last_col = (cx == eff_w - (X_W+1)'(1));
    assign last_row = (cy == eff_h - (Y_W+1)'(1));

    always_ff @(posedge clock) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nstate;
    end

    always_comb begin
        nstate = state;
        pop    = 1'b0;
        draw   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    nstate = (clip_w == '0 || clip_h == '0) ? S_FINISH : S_DRAW;
                end
            end
            S_DRAW: begin
                draw = 1'b1;
                if (last_col && last_row) nstate = S_FINISH;
            end
            S_FINISH: nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
        if (abort) begin
            nstate = S_IDLE;
            pop    = 1'b0;
            draw   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            base_x <= '0;
            base_y <= '0;
            eff_w  <= '0;
            eff_h  <= '0;
            fill   <= '0;
            cx     <= '0;
            cy     <= '0;
        end else if (pop) begin
            base_x <= (h_mode == MODE_CLEAR) ? '0 : h_x;
            base_y <= (h_mode == MODE_CLEAR) ? '0 : h_y;
            eff_w  <= clip_w;
            eff_h  <= clip_h;
            fill   <= h_colour;
            cx     <= '0;
            cy     <= '0;
        end else if (draw) begin
            if (last_col) begin
                cx <= '0;
                cy <= cy + (Y_W+1)'(1);
            end else begin
                cx <= cx + (X_W+1)'(1);
            end
        end
    end

    // Pixel outputs are registered; x/y/colour hold their last value when idle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            done   <= 1'b0;
        end else begin
            plot <= draw;
            done <= (state == S_FINISH) && !abort;
            if (draw) begin
                x      <= base_x + cx[X_W-1:0];
                y      <= base_y + cy[Y_W-1:0];
                colour <= fill;
            end
        end
    end

endmodule

// File: tb/tb_rect_plot_engine.sv
// Scoreboard bench for rect_plot_engine: a screen-membership model queues the
// expected pixel/done stream, an independent monitor consumes it.
module tb_rect_plot_engine;

    localparam int X_W = 8, Y_W = 7, SW = 160, SH = 120, CW = 3, DEPTH = 4;

    logic clock = 1'b0, resetn = 1'b0, abort = 1'b0;
    logic cmd_valid = 1'b0, cmd_mode = 1'b0;
    logic [X_W-1:0] cmd_x = '0, cmd_w = '0;
    logic [Y_W-1:0] cmd_y = '0, cmd_h = '0;
    logic [CW-1:0]  cmd_colour = '0;
    logic cmd_ready, plot, busy, done;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [CW-1:0]  colour;
    logic [$clog2(DEPTH):0] fifo_count;

    rect_plot_engine #(
        .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH),
        .COLOUR_W(CW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .resetn(resetn), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_colour(cmd_colour), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .done(done), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    typedef struct { bit is_done; int x; int y; int c; } ev_t;
    ev_t exp_q[$];

    int ntests = 0, nfail = 0, cyc = 0;
    int n_plot = 0, n_done = 0, first_plot = -1, last_plot = -1, last_done = -1;
    int last_accept = 0;
    bit gap_chk = 0, full_chk = 0, saw_full = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected stream: every on-screen pixel of the rectangle in raster order, then done.
    task automatic model(input bit mode, input int x0, input int y0, input int w, input int h, input int c);
        ev_t e;
        int xs, ys, ws, hs;
        xs = x0; ys = y0; ws = w; hs = h;
        if (mode) begin xs = 0; ys = 0; ws = SW; hs = SH; end
        for (int r = ys; r < ys + hs; r++)
            for (int q = xs; q < xs + ws; q++)
                if (q < SW && r < SH) begin
                    e.is_done = 0; e.x = q; e.y = r; e.c = c;
                    exp_q.push_back(e);
                end
        e.is_done = 1; e.x = 0; e.y = 0; e.c = 0;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        ev_t e;
        if (plot) begin
            n_plot++;
            if (first_plot < 0) first_plot = cyc;
            if (gap_chk && last_plot >= 0 && cyc != last_plot + 1)
                chk("inter_cmd_gap", cyc - last_plot - 1, 2);
            last_plot = cyc;
            ntests++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL pixel: unexpected plot at (%0d,%0d)", x, y);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done || int'(x) != e.x || int'(y) != e.y || int'(colour) != e.c) begin
                    nfail++;
                    $display("FAIL pixel: got (%0d,%0d) c%0d, expected done=%0d (%0d,%0d) c%0d",
                             x, y, colour, e.is_done, e.x, e.y, e.c);
                end
            end
        end
        if (done) begin
            n_done++;
            last_done = cyc;
            ntests++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL done: unexpected done pulse");
            end else begin
                e = exp_q.pop_front();
                if (!e.is_done) begin
                    nfail++;
                    $display("FAIL done: got done, expected pixel (%0d,%0d) c%0d", e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic send(input bit mode, input int x0, input int y0, input int w, input int h, input int c);
        int n;
        n = 0;
        @(negedge clock);
        cmd_mode = mode; cmd_x = X_W'(x0); cmd_y = Y_W'(y0);
        cmd_w = X_W'(w); cmd_h = Y_W'(h); cmd_colour = CW'(c);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin
            if (full_chk && !saw_full) begin
                saw_full = 1;
                chk("full_count_at_ready_low", int'(fifo_count), DEPTH);
            end
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            ntests++; nfail++;
            $display("FAIL accept: cmd_ready stayed low for %0d cycles", n);
        end else begin
            last_accept = cyc + 1;
            model(mode, x0, y0, w, h, c);
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound, output int busy_low);
        int n;
        n = 0; busy_low = 0;
        while (n_done < target && n < bound) begin
            @(negedge clock);
            #1;
            n++;
            if (n_done < target && !busy) busy_low++;
        end
        if (n_done < target) begin
            ntests++; nfail++;
            $display("FAIL done_timeout: got %0d done pulses, expected %0d", n_done, target);
        end
    endtask

    // Interrupt a drawing rectangle with two commands queued, by abort or by reset.
    task automatic interrupt_test(input bit use_reset);
        int p0, d0, n;
        p0 = n_plot;
        send(0, 30, 40, 20, 10, 5);
        send(0, 60, 60, 5, 5, 2);
        send(0, 70, 70, 5, 5, 3);
        n = 0;
        while (n_plot < p0 + 5 && n < 500) begin @(negedge clock); #1; n++; end
        @(negedge clock);
        chk("queued_before_interrupt", int'(fifo_count), 2);
        if (use_reset) resetn = 1'b0;
        else           abort  = 1'b1;
        cmd_valid = 1'b1; cmd_mode = 0; cmd_x = 8'd1; cmd_y = 7'd1;
        cmd_w = 8'd2; cmd_h = 7'd2; cmd_colour = 3'd7;
        @(posedge clock);
        #1;
        abort = 1'b0; resetn = 1'b1; cmd_valid = 1'b0;
        @(negedge clock);
        #1;
        chk("intr_plot", int'(plot), 0);
        chk("intr_done", int'(done), 0);
        chk("intr_fifo_count", int'(fifo_count), 0);
        chk("intr_busy", int'(busy), 0);
        chk("intr_cmd_ready", int'(cmd_ready), 1);
        if (use_reset) begin
            chk("rst_x", int'(x), 0);
            chk("rst_y", int'(y), 0);
            chk("rst_colour", int'(colour), 0);
        end
        exp_q.delete();
        p0 = n_plot; d0 = n_done;
        repeat (6) @(negedge clock);
        #1;
        chk("intr_no_more_plots", n_plot - p0, 0);
        chk("intr_no_done", n_done - d0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        nfail++;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0, a, bl;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_plot", int'(plot), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_x", int'(x), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_colour", int'(colour), 0);
        chk("reset_fifo_count", int'(fifo_count), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        resetn = 1'b1;

        // Basic rectangle: count, latency, done timing.
        p0 = n_plot; d0 = n_done; first_plot = -1;
        send(0, 10, 110, 4, 4, 1);
        a = last_accept;
        wait_done(d0 + 1, 200, bl);
        chk("rect_plots", n_plot - p0, 16);
        chk("rect_first_plot_latency", first_plot - a, 2);
        chk("rect_done_after_last_plot", last_done - last_plot, 1);

        // Full-screen clear, command geometry must be ignored.
        p0 = n_plot; d0 = n_done;
        send(1, 5, 7, 3, 2, 0);
        wait_done(d0 + 1, 20000, bl);
        chk("clear_plots", n_plot - p0, SW * SH);
        chk("clear_busy_low_cycles", bl, 0);
        chk("clear_done_count", n_done - d0, 1);

        // Bottom-right corner clip.
        p0 = n_plot; d0 = n_done;
        send(0, 158, 118, 4, 4, 6);
        wait_done(d0 + 1, 200, bl);
        chk("clip_plots", n_plot - p0, 4);
        chk("clip_done_after_last_plot", last_done - last_plot, 1);

        // Off-screen and zero-width commands.
        p0 = n_plot; d0 = n_done;
        send(0, 170, 10, 5, 5, 4);
        a = last_accept;
        wait_done(d0 + 1, 50, bl);
        chk("offscreen_plots", n_plot - p0, 0);
        chk("offscreen_done_latency", last_done - a, 2);
        p0 = n_plot; d0 = n_done;
        send(0, 20, 20, 0, 5, 4);
        a = last_accept;
        wait_done(d0 + 1, 50, bl);
        chk("zero_w_plots", n_plot - p0, 0);
        chk("zero_w_done_latency", last_done - a, 2);
        p0 = n_plot; d0 = n_done;
        send(0, 20, 20, 5, 0, 4);
        wait_done(d0 + 1, 50, bl);
        chk("zero_h_plots", n_plot - p0, 0);

        // Six back-to-back commands into a four-deep queue.
        d0 = n_done; gap_chk = 1; full_chk = 1; saw_full = 0; last_plot = -1;
        for (int i = 0; i < 6; i++) send(0, 10 + i * 20, 5 + i * 10, 8, 4, i + 1);
        wait_done(d0 + 6, 2000, bl);
        chk("b2b_ready_dropped", int'(saw_full), 1);
        chk("b2b_done_count", n_done - d0, 6);
        gap_chk = 0; full_chk = 0;

        interrupt_test(0);
        interrupt_test(1);

        // Randomised rectangles, some clipped or empty.
        d0 = n_done;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            send(0, $urandom_range(0, 200), $urandom_range(0, 127),
                 $urandom_range(0, 24), $urandom_range(0, 20), $urandom_range(0, 7));
        end
        wait_done(d0 + 20, 40000, bl);
        repeat (4) @(negedge clock);
        chk("leftover_expected_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
